// File: rtl/hazard_unit.sv
// Pipeline hazard controller: resolves memory waits, taken branches and load-use
// hazards into stall/flush controls, and keeps saturating stall/flush counters.
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1end,
    input  logic [4:0]  id_rs2end,
    input  logic        id_usesRs1,
    input  logic        id_usesRs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_lw,
    input  logic        ex_EscReg,
    input  logic        branch_taken,
    input  logic        mem_ready,
    input  logic        countClr,
    output logic        pcStall,
    output logic        ifidStall,
    output logic        idexStall,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic [1:0]  state,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_n;
    logic        hazard_raw;
    logic        load_use;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    assign hazard_raw = ex_lw && ex_EscReg && (ex_rd != 5'd0) &&
                        ((id_usesRs1 && (id_rs1end == ex_rd)) ||
                         (id_usesRs2 && (id_rs2end == ex_rd)));

    // The bubble cycle already separated the load from its consumer.
    assign load_use = hazard_raw && (state_q != BUBBLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n   = RUN;
        pcStall   = 1'b0;
        ifidStall = 1'b0;
        idexStall = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        if (!reset) begin
            state_n = RUN;
        end else if (!mem_ready) begin
            // A pending branch flush waits here; EX is frozen so it reappears.
            state_n   = MEM_WAIT;
            pcStall   = 1'b1;
            ifidStall = 1'b1;
            idexStall = 1'b1;
        end else if (branch_taken) begin
            state_n   = RUN;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (load_use) begin
            state_n   = (state_q == RUN) ? BUBBLE : RUN;
            pcStall   = 1'b1;
            ifidStall = 1'b1;
            idexFlush = 1'b1;
        end else begin
            state_n = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (countClr) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (pcStall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ifidFlush && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign state      = state_q;
    assign stallCount = stall_cnt;
    assign flushCount = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a rule-level model.
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1end;
    logic [4:0]  id_rs2end;
    logic        id_usesRs1;
    logic        id_usesRs2;
    logic [4:0]  ex_rd;
    logic        ex_lw;
    logic        ex_EscReg;
    logic        branch_taken;
    logic        mem_ready;
    logic        countClr;
    logic        pcStall;
    logic        ifidStall;
    logic        idexStall;
    logic        ifidFlush;
    logic        idexFlush;
    logic [1:0]  state;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model state: plain integers, counters kept wide and capped numerically.
    int              m_state;
    int              m_state_next;
    longint unsigned m_stall;
    longint unsigned m_flush;
    longint unsigned m_stall_next;
    longint unsigned m_flush_next;
    localparam longint unsigned CNT_MAX = 64'd4294967295;

    hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1end    (id_rs1end),
        .id_rs2end    (id_rs2end),
        .id_usesRs1   (id_usesRs1),
        .id_usesRs2   (id_usesRs2),
        .ex_rd        (ex_rd),
        .ex_lw        (ex_lw),
        .ex_EscReg    (ex_EscReg),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .countClr     (countClr),
        .pcStall      (pcStall),
        .ifidStall    (ifidStall),
        .idexStall    (idexStall),
        .ifidFlush    (ifidFlush),
        .idexFlush    (idexFlush),
        .state        (state),
        .stallCount   (stallCount),
        .flushCount   (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        id_rs1end = 5'd0; id_rs2end = 5'd0; id_usesRs1 = 1'b0; id_usesRs2 = 1'b0;
        ex_rd = 5'd0; ex_lw = 1'b0; ex_EscReg = 1'b0;
        branch_taken = 1'b0; mem_ready = 1'b1; countClr = 1'b0;
    endtask

    task automatic load_use_inputs();
        idle_inputs();
        ex_lw = 1'b1; ex_EscReg = 1'b1; ex_rd = 5'd5;
        id_rs2end = 5'd5; id_usesRs2 = 1'b1;
    endtask

    task automatic rand_inputs();
        id_rs1end    = 5'($urandom_range(0, 3));
        id_rs2end    = 5'($urandom_range(0, 3));
        id_usesRs1   = 1'($urandom_range(0, 1));
        id_usesRs2   = 1'($urandom_range(0, 1));
        ex_rd        = 5'($urandom_range(0, 3));
        ex_lw        = ($urandom_range(0, 99) < 60);
        ex_EscReg    = ($urandom_range(0, 99) < 80);
        branch_taken = ($urandom_range(0, 99) < 20);
        mem_ready    = ($urandom_range(0, 99) < 80);
        countClr     = ($urandom_range(0, 99) < 3);
    endtask

    // Compare DUT against the model for the current inputs, then advance one clock.
    task automatic step();
        logic [4:0] exp_o;
        logic [4:0] act_o;
        bit         hz;
        #1;
        hz = ex_lw && ex_EscReg && (ex_rd != 0) &&
             ((id_usesRs1 && id_rs1end == ex_rd) || (id_usesRs2 && id_rs2end == ex_rd));
        exp_o          = 5'b00000;
        m_state_next   = 0;
        m_stall_next   = m_stall;
        m_flush_next   = m_flush;
        if (!reset) begin
            m_stall_next = 0;
            m_flush_next = 0;
        end else begin
            if (!mem_ready) begin
                exp_o = 5'b11100;
                m_state_next = 2;
            end else if (branch_taken) begin
                exp_o = 5'b00011;
            end else if (hz && m_state != 1) begin
                exp_o = 5'b11001;
                if (m_state == 0) m_state_next = 1;
            end
            if (countClr) begin
                m_stall_next = 0;
                m_flush_next = 0;
            end else begin
                if (exp_o[4] && m_stall < CNT_MAX) m_stall_next = m_stall + 1;
                if (exp_o[1] && m_flush < CNT_MAX) m_flush_next = m_flush + 1;
            end
        end
        act_o = {pcStall, ifidStall, idexStall, ifidFlush, idexFlush};
        chk("outputs", 32'(act_o), 32'(exp_o));
        chk("state", 32'(state), 32'(m_state));
        chk("stallCount", stallCount, m_stall[31:0]);
        chk("flushCount", flushCount, m_flush[31:0]);
        @(posedge clk);
        m_state = m_state_next;
        m_stall = m_stall_next;
        m_flush = m_flush_next;
        @(negedge clk);
    endtask

    initial begin
        m_state = 0; m_stall = 0; m_flush = 0;
        idle_inputs();
        reset = 1'b0;
        mem_ready = 1'b0;
        branch_taken = 1'b1;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_stallCount", stallCount, 32'd0);
        chk("rst_outputs", 32'({pcStall, ifidStall, idexStall, ifidFlush, idexFlush}), 32'd0);
        @(negedge clk);
        step();
        reset = 1'b1;
        idle_inputs();
        step();

        // Load-use: one bubble, then the suppressed check lets the pipeline go.
        load_use_inputs();
        #1;
        chk("lu_pcStall", 32'(pcStall), 32'd1);
        chk("lu_idexFlush", 32'(idexFlush), 32'd1);
        chk("lu_idexStall", 32'(idexStall), 32'd0);
        step();
        #1;
        chk("lu_bubble_state", 32'(state), 32'd1);
        chk("lu_bubble_pcStall", 32'(pcStall), 32'd0);
        chk("lu_stallCount", stallCount, 32'd1);
        step();
        idle_inputs();
        #1;
        chk("lu_back_run", 32'(state), 32'd0);
        step();

        // Branch together with the hazard: flush only.
        load_use_inputs();
        branch_taken = 1'b1;
        #1;
        chk("br_ifidFlush", 32'(ifidFlush), 32'd1);
        chk("br_pcStall", 32'(pcStall), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("br_flushCount", flushCount, 32'd1);
        chk("br_stallCount", stallCount, 32'd1);
        chk("br_state", 32'(state), 32'd0);
        step();

        // Three memory-wait cycles.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        mem_ready = 1'b1;
        #1;
        chk("mw_state", 32'(state), 32'd2);
        chk("mw_stallCount", stallCount, 32'd4);
        chk("mw_release_out", 32'({pcStall, ifidStall, idexStall}), 32'd0);
        step();

        // Zero destination never stalls.
        idle_inputs();
        ex_lw = 1'b1; ex_EscReg = 1'b1; ex_rd = 5'd0; id_rs1end = 5'd0; id_usesRs1 = 1'b1;
        #1;
        chk("x0_pcStall", 32'(pcStall), 32'd0);
        step();

        // Memory wait with a pending branch: freeze, then flush once memory is ready.
        idle_inputs();
        mem_ready = 1'b0; branch_taken = 1'b1;
        #1;
        chk("mwbr_flush_held", 32'(ifidFlush), 32'd0);
        step();
        mem_ready = 1'b1;
        #1;
        chk("mwbr_flush", 32'(idexFlush), 32'd1);
        step();

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            step();
        end

        // Clear beats a concurrent stall increment.
        idle_inputs();
        mem_ready = 1'b0; countClr = 1'b1;
        step();
        countClr = 1'b0;
        #1;
        chk("clr_stallCount", stallCount, 32'd0);
        step();

        // Saturation: preload near the top, then keep stalling / flushing.
        idle_inputs();
        force dut.stall_cnt = 32'hFFFF_FFFD;
        force dut.flush_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        release dut.flush_cnt;
        m_stall = 64'hFFFF_FFFD;
        m_flush = 64'hFFFF_FFFE;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        mem_ready = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle_inputs();
        #1;
        chk("sat_stallCount", stallCount, 32'hFFFF_FFFF);
        chk("sat_flushCount", flushCount, 32'hFFFF_FFFF);
        step();

        // Asynchronous reset in the middle of a memory wait.
        mem_ready = 1'b0;
        step();
        step();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_stallCount", stallCount, 32'd0);
        chk("arst_flushCount", flushCount, 32'd0);
        chk("arst_outputs", 32'({pcStall, ifidStall, idexStall, ifidFlush, idexFlush}), 32'd0);
        m_state = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        step();
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
